// File: rtl/key_scan_pkg.sv
// Shared types and constants for the keypad scan controller.
package key_scan_pkg;

  localparam int unsigned SCAN_LEN = 8;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_class_t;

  localparam logic [3:0] HL_OFF = 4'b1111;

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/key_frame_sampler.sv
// Row scan counter, row drive, per-row column sampling and per-frame key classification.
module key_frame_sampler
  import key_scan_pkg::*;
(
  input  logic         clk1,
  input  logic         rst,
  input  logic [3:0]   vl,
  output logic [3:0]   hl,
  output logic         frame_done,
  output frame_class_t frame_class,
  output logic [3:0]   frame_code
);

  logic [2:0]  sc;
  logic [2:0]  sc_next;
  logic [11:0] acc;
  logic [15:0] closed;
  logic [4:0]  n_closed;
  logic [3:0]  last_idx;

  assign sc_next = sc + 3'd1;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      sc  <= 3'd7;
      hl  <= HL_OFF;
      acc <= '0;
    end else begin
      sc <= sc_next;
      hl <= ROW_DRIVE[sc_next[2:1]];
      // Odd counts sample the row driven since the previous (settle) cycle.
      case (sc)
        3'd1:    acc[3:0]  <= ~vl;
        3'd3:    acc[7:4]  <= ~vl;
        3'd5:    acc[11:8] <= ~vl;
        3'd7:    acc       <= '0;
        default: ;
      endcase
    end
  end

  // Row 3 is taken live at the frame-end edge rather than from the accumulator.
  assign closed     = {~vl, acc};
  assign frame_done = (sc == 3'd7);

  always_comb begin
    n_closed = '0;
    last_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (closed[i]) begin
        n_closed = n_closed + 5'd1;
        last_idx = 4'(i);
      end
    end
    frame_code = last_idx;
    if (n_closed == 5'd0)
      frame_class = FRAME_NONE;
    else if (n_closed == 5'd1)
      frame_class = FRAME_SINGLE;
    else
      frame_class = FRAME_MULTI;
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner with whole-frame debounce; one key_valid pulse per accepted press.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [3:0] vl,
  output logic [3:0] hl,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_err
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_FRAMES);

  logic         frame_done;
  frame_class_t frame_class;
  logic [3:0]   frame_code;

  state_t     state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic       fire;

  key_frame_sampler u_sampler (
    .clk1        (clk1),
    .rst         (rst),
    .vl          (vl),
    .hl          (hl),
    .frame_done  (frame_done),
    .frame_class (frame_class),
    .frame_code  (frame_code)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= fire;
      if (fire)
        key_code <= cand_n;
      key_held  <= (state_n == PRESSED) || (state_n == RELEASE);
      multi_err <= frame_done && (frame_class == FRAME_MULTI);
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    fire    = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_class == FRAME_SINGLE) begin
            cand_n = frame_code;
            cnt_n  = 4'd1;
            if (DB_N == 4'd1) begin
              state_n = PRESSED;
              fire    = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_class == FRAME_SINGLE) begin
            if (frame_code == cand) begin
              cnt_n = cnt + 4'd1;
              if (cnt + 4'd1 == DB_N) begin
                state_n = PRESSED;
                fire    = 1'b1;
              end
            end else begin
              cand_n = frame_code;
              cnt_n  = 4'd1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          // Other keys are ignored until a full release: no rollover.
          if (frame_class == FRAME_NONE) begin
            cnt_n   = 4'd1;
            state_n = (DB_N == 4'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (frame_class == FRAME_NONE) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DB_N)
              state_n = IDLE;
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: keypad matrix model plus event scoreboard.
module tb_key_scan_ctrl;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] vl, vl1;
  logic [3:0] hl, hl1;
  logic       key_valid, key_valid1;
  logic [3:0] key_code, key_code1;
  logic       key_held, key_held1;
  logic       multi_err, multi_err1;

  logic [15:0] keys  = '0;
  logic [15:0] keys1 = '0;

  typedef struct {
    int         edge_no;
    logic [3:0] code;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  int  nvec     = 0;
  int  nfail    = 0;
  int  n_multi  = 0;
  int  n_valid1 = 0;
  int  ecnt;

  always #5 clk1 = ~clk1;

  key_scan_ctrl #(.DEBOUNCE_FRAMES(3)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .vl        (vl),
    .hl        (hl),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  key_scan_ctrl #(.DEBOUNCE_FRAMES(1)) dut1 (
    .clk1      (clk1),
    .rst       (rst),
    .vl        (vl1),
    .hl        (hl1),
    .key_valid (key_valid1),
    .key_code  (key_code1),
    .key_held  (key_held1),
    .multi_err (multi_err1)
  );

  // Keypad matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    vl = '1;
    for (int r = 0; r < 4; r++)
      if (!hl[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) vl[c] = 1'b0;
  end

  always_comb begin
    vl1 = '1;
    for (int r = 0; r < 4; r++)
      if (!hl1[r])
        for (int c = 0; c < 4; c++)
          if (keys1[r*4+c]) vl1[c] = 1'b0;
  end

  // Edge 0 is the first rising edge after reset release.
  always @(posedge clk1 or posedge rst)
    if (rst) ecnt <= -1;
    else     ecnt <= ecnt + 1;

  always @(negedge clk1) begin
    if (!rst) begin
      if (key_valid) begin
        nvec++;
        if (sb.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_event: got code %h at edge %0d, required no event", key_code, ecnt);
        end else begin
          mon_ev = sb.pop_front();
          if (mon_ev.edge_no != ecnt || key_code !== mon_ev.code) begin
            nfail++;
            $display("FAIL event: got code %h at edge %0d, required code %h at edge %0d",
                     key_code, ecnt, mon_ev.code, mon_ev.edge_no);
          end
        end
      end
      if (multi_err)  n_multi++;
      if (key_valid1) n_valid1++;
    end
  end

  task automatic do_reset(input logic [15:0] m, input logic [15:0] m1);
    #3 rst = 1'b1;
    keys  = m;
    keys1 = m1;
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    @(posedge clk1);
    #1;
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    keys = m;
    repeat (8*n) @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_hl;
    keys = '0; keys1 = '0;
    @(negedge clk1);
    rst = 1'b0;
    repeat (5) @(posedge clk1);
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (hl !== 4'b1111 || key_valid !== 1'b0 || key_code !== 4'h0 || key_held !== 1'b0 || multi_err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got hl=%b v=%b code=%h held=%b multi=%b, required 1111 0 0 0 0",
               hl, key_valid, key_code, key_held, multi_err);
    end
    @(negedge clk1);
    rst = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk1);
      #1;
      exp_hl = ~(4'b0001 << ((e % 8) / 2));
      nvec++;
      if (hl !== exp_hl) begin
        nfail++;
        $display("FAIL hl_scan: edge %0d got %b, required %b", e, hl, exp_hl);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [15:0] m;
    m = 16'h1 << 6;
    do_reset(m, '0);
    sb.push_back('{edge_no: 24, code: 4'h6});
    frames(m, 2);
    nvec++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      nfail++;
      $display("FAIL clean_pre_accept: got held=%b valid=%b, required 0 0", key_held, key_valid);
    end
    frames(m, 1);
    nvec++;
    if (key_held !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'h6) begin
      nfail++;
      $display("FAIL clean_accept: got held=%b valid=%b code=%h, required 1 1 6", key_held, key_valid, key_code);
    end
    frames(m, 3);
    frames('0, 3);
    nvec++;
    if (key_held !== 1'b0 || key_code !== 4'h6) begin
      nfail++;
      $display("FAIL clean_release: got held=%b code=%h, required 0 6", key_held, key_code);
    end
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL clean_missing: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_press_bounce();
    logic [15:0] m;
    m = 16'h1 << 11;
    do_reset(m, '0);
    frames(m, 2);
    frames('0, 1);
    sb.push_back('{edge_no: ecnt + 24, code: 4'hB});
    frames(m, 2);
    nvec++;
    if (key_held !== 1'b0) begin
      nfail++;
      $display("FAIL bounce_early: got held=%b, required 0", key_held);
    end
    frames(m, 1);
    nvec++;
    if (key_held !== 1'b1 || key_code !== 4'hB) begin
      nfail++;
      $display("FAIL bounce_accept: got held=%b code=%h, required 1 b", key_held, key_code);
    end
    frames(m, 1);
    frames('0, 3);
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL bounce_missing: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_release_bounce();
    logic [15:0] m;
    m = 16'h1 << 5;
    do_reset(m, '0);
    sb.push_back('{edge_no: 24, code: 4'h5});
    frames(m, 3);
    frames('0, 1);
    nvec++;
    if (key_held !== 1'b1) begin
      nfail++;
      $display("FAIL release_first_open: got held=%b, required 1", key_held);
    end
    frames(m, 1);
    frames('0, 2);
    nvec++;
    if (key_held !== 1'b1) begin
      nfail++;
      $display("FAIL release_second_open: got held=%b, required 1", key_held);
    end
    frames('0, 1);
    nvec++;
    if (key_held !== 1'b0) begin
      nfail++;
      $display("FAIL release_done: got held=%b, required 0", key_held);
    end
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL release_missing: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_two_keys();
    logic [15:0] m;
    int mc0;
    m = (16'h1 << 1) | (16'h1 << 7);
    do_reset(m, '0);
    mc0 = n_multi;
    for (int f = 0; f < 3; f++) begin
      frames(m, 1);
      nvec++;
      if (multi_err !== 1'b1 || key_held !== 1'b0) begin
        nfail++;
        $display("FAIL multi_frame: frame %0d got multi=%b held=%b, required 1 0", f, multi_err, key_held);
      end
    end
    sb.push_back('{edge_no: ecnt + 24, code: 4'h1});
    frames(16'h1 << 1, 3);
    nvec++;
    if (multi_err !== 1'b0 || key_held !== 1'b1 || key_code !== 4'h1) begin
      nfail++;
      $display("FAIL multi_single: got multi=%b held=%b code=%h, required 0 1 1", multi_err, key_held, key_code);
    end
    nvec++;
    if (n_multi - mc0 != 3) begin
      nfail++;
      $display("FAIL multi_pulses: got %0d cycles, required 3", n_multi - mc0);
    end
    frames('0, 3);
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL multi_missing: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_press();
    logic [15:0] m;
    m = 16'h1 << 9;
    do_reset(m, '0);
    sb.push_back('{edge_no: 24, code: 4'h9});
    frames(m, 4);
    nvec++;
    if (key_held !== 1'b1 || key_code !== 4'h9) begin
      nfail++;
      $display("FAIL midrst_pressed: got held=%b code=%h, required 1 9", key_held, key_code);
    end
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0 || hl !== 4'b1111) begin
      nfail++;
      $display("FAIL midrst_clear: got held=%b valid=%b code=%h hl=%b, required 0 0 0 1111",
               key_held, key_valid, key_code, hl);
    end
    do_reset(m, '0);
    sb.push_back('{edge_no: ecnt + 24, code: 4'h9});
    frames(m, 2);
    nvec++;
    if (key_held !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_redebounce: got held=%b, required 0", key_held);
    end
    frames(m, 1);
    nvec++;
    if (key_held !== 1'b1 || key_valid !== 1'b1) begin
      nfail++;
      $display("FAIL midrst_accept: got held=%b valid=%b, required 1 1", key_held, key_valid);
    end
    frames('0, 3);
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL midrst_missing: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_single_frame();
    int v0;
    do_reset('0, 16'h1 << 12);
    v0 = n_valid1;
    repeat (8) @(posedge clk1);
    #1;
    nvec++;
    if (key_valid1 !== 1'b1 || key_code1 !== 4'hC || key_held1 !== 1'b1) begin
      nfail++;
      $display("FAIL d1_accept: got valid=%b code=%h held=%b, required 1 c 1", key_valid1, key_code1, key_held1);
    end
    @(posedge clk1);
    #1;
    nvec++;
    if (key_valid1 !== 1'b0) begin
      nfail++;
      $display("FAIL d1_pulse_width: got valid=%b, required 0", key_valid1);
    end
    keys1 = '0;
    repeat (7) @(posedge clk1);
    #1;
    nvec++;
    if (key_held1 !== 1'b0) begin
      nfail++;
      $display("FAIL d1_release: got held=%b, required 0", key_held1);
    end
    nvec++;
    if (n_valid1 - v0 != 1) begin
      nfail++;
      $display("FAIL d1_event_count: got %0d, required 1", n_valid1 - v0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_two_keys();
    test_reset_mid_press();
    test_single_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
